// File: rtl/uart_arbiter_pkg.sv
// Shared definitions for the uart_arbiter block.
//   - FSM state constants (IDLE / GUARD / WAIT)
//   - source-index type (one bit: 0 = LPC record stream, 1 = status reporter)
//   - default GUARD and TIMEOUT values
package uart_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StIdle  = 2'd0;
  localparam arb_state_t StGuard = 2'd1;
  localparam arb_state_t StWait  = 2'd2;

  typedef logic src_idx_t;

  localparam int unsigned GuardDefault   = 2;
  localparam int unsigned TimeoutDefault = 4096;

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way round-robin picker.
// Ports:
//   valid  - per-source byte-available flags
//   owner  - source of the current/last granted frame
//   locked - a frame is in progress; only the owner may continue it
//   grant  - some source is eligible this cycle
//   index  - the selected source (meaningful when grant=1)
module arb_rr2
  import uart_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  src_idx_t   owner,
  input  logic       locked,
  output logic       grant,
  output src_idx_t   index
);

  always_comb begin
    grant = 1'b0;
    index = owner;
    if (locked) begin
      grant = valid[owner];
    end else begin
      case (valid)
        // Contention: the source that did not own the last frame wins.
        2'b11: begin
          grant = 1'b1;
          index = ~owner;
        end
        2'b01: begin
          grant = 1'b1;
          index = 1'b0;
        end
        2'b10: begin
          grant = 1'b1;
          index = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_arbiter.sv
// Frame-atomic round-robin arbiter sharing the uart_tx byte channel between
// source 0 (LPC record stream) and source 1 (status/heartbeat reporter).
// Optional feature macro: UART_ARB_TIMEOUT_EN (forced release of a stalled
// locked frame after TIMEOUT idle cycles, sticky timeout_flag).
// Ports:
//   clock, reset                   - clock, async active-low reset
//   s0_valid/s0_data/s0_last/s0_ack - source 0 byte handshake
//   s1_valid/s1_data/s1_last/s1_ack - source 1 byte handshake
//   uart_ready                     - uart_tx idle
//   uart_data, uart_clock_enable   - byte and one-cycle issue strobe to uart_tx
//   owner, locked                  - current/last frame owner, frame in progress
//   timeout_flag                   - sticky frame-timeout error (0 without macro)
module uart_arbiter
  import uart_arbiter_pkg::*;
#(
  parameter int unsigned GUARD = GuardDefault
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = TimeoutDefault
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ack,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ack,
  input  logic       uart_ready,
  output logic [7:0] uart_data,
  output logic       uart_clock_enable,
  output src_idx_t   owner,
  output logic       locked,
  output logic       timeout_flag
);

  localparam int unsigned GuardW = $clog2(GUARD + 1);

  arb_state_t        state_q, state_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic [7:0]        data_d;
  logic              strobe_d, ack0_d, ack1_d, locked_d;
  src_idx_t          owner_d;

  logic [1:0] valid_vec;
  logic       grant;
  src_idx_t   sel;
  logic       issue;

  assign valid_vec = {s1_valid, s0_valid};

  arb_rr2 u_arb (
    .valid  (valid_vec),
    .owner  (owner),
    .locked (locked),
    .grant  (grant),
    .index  (sel)
  );

  assign issue = (state_q == StIdle) && uart_ready && grant;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TimeoutW = $clog2(TIMEOUT + 1);
  logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
  logic                flag_d;
`endif

  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    data_d   = uart_data;
    strobe_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    owner_d  = owner;
    locked_d = locked;

    case (state_q)
      StIdle: begin
        if (issue) begin
          data_d   = sel ? s1_data : s0_data;
          strobe_d = 1'b1;
          ack0_d   = ~sel;
          ack1_d   = sel;
          owner_d  = sel;
          // The last byte releases the lock on the same edge it is issued.
          locked_d = ~(sel ? s1_last : s0_last);
          guard_d  = GuardW'(GUARD);
          state_d  = StGuard;
        end
      end
      StGuard: begin
        // uart_ready is stale for a few cycles after a strobe; ignore it here.
        if (guard_q <= GuardW'(1)) begin
          guard_d = '0;
          state_d = StWait;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      StWait: begin
        if (uart_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    flag_d   = timeout_flag;
    if (issue) begin
      to_cnt_d = '0;
    end else if ((state_q == StIdle) && locked && !valid_vec[owner]) begin
      if (to_cnt_q == TimeoutW'(TIMEOUT - 1)) begin
        to_cnt_d = '0;
        locked_d = 1'b0;
        flag_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      guard_q           <= '0;
      uart_data         <= '0;
      uart_clock_enable <= 1'b0;
      s0_ack            <= 1'b0;
      s1_ack            <= 1'b0;
      owner             <= 1'b1;  // source 0 wins the first tie
      locked            <= 1'b0;
    end else begin
      state_q           <= state_d;
      guard_q           <= guard_d;
      uart_data         <= data_d;
      uart_clock_enable <= strobe_d;
      s0_ack            <= ack0_d;
      s1_ack            <= ack1_d;
      owner             <= owner_d;
      locked            <= locked_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_q     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      to_cnt_q     <= to_cnt_d;
      timeout_flag <= flag_d;
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_uart_arbiter.sv
// Self-checking bench for uart_arbiter: frame-level reference model of the
// arbitration rules, a uart_tx model with stale ready after each strobe,
// table-driven arbitration vectors, directed corner cases and random traffic.
module tb_uart_arbiter;

  localparam int unsigned GuardTb = 2;

  logic       clock, reset;
  logic       s0_valid, s0_last, s0_ack, s1_valid, s1_last, s1_ack;
  logic [7:0] s0_data, s1_data, uart_data;
  logic       uart_ready, uart_clock_enable, owner, locked, timeout_flag;

  uart_arbiter #(
    .GUARD(GuardTb)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .s0_valid          (s0_valid),
    .s0_data           (s0_data),
    .s0_last           (s0_last),
    .s0_ack            (s0_ack),
    .s1_valid          (s1_valid),
    .s1_data           (s1_data),
    .s1_last           (s1_last),
    .s1_ack            (s1_ack),
    .uart_ready        (uart_ready),
    .uart_data         (uart_data),
    .uart_clock_enable (uart_clock_enable),
    .owner             (owner),
    .locked            (locked),
    .timeout_flag      (timeout_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed { logic [7:0] data; logic last; } byte_t;
  typedef struct packed { logic src; logic [7:0] data; } issue_t;
  typedef struct {
    bit v0; bit v1; logic [7:0] d0; logic [7:0] d1; bit l0; bit l1; int n_issue;
    bit exp_src; logic [7:0] exp_data; bit exp_owner; bit exp_locked;
  } row_t;

  byte_t  srcq0[$];
  byte_t  srcq1[$];
  issue_t log_q[$];
  row_t   rows[8];

  int checks = 0, errors = 0;
  int cyc = 0, strobes = 0, last_strobe = -100;
  int busy = 0, stale = 0, d_min = 3, d_max = 3;
  bit m_owner = 1'b1, m_locked = 1'b0, chk_lock = 1'b1;
  logic [7:0] m_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    s0_valid = srcq0.size() > 0;
    s0_data  = s0_valid ? srcq0[0].data : 8'h00;
    s0_last  = s0_valid ? srcq0[0].last : 1'b0;
    s1_valid = srcq1.size() > 0;
    s1_data  = s1_valid ? srcq1[0].data : 8'h00;
    s1_last  = s1_valid ? srcq1[0].last : 1'b0;
  endtask

  task automatic push(input bit k, input logic [7:0] d, input bit l);
    if (k) srcq1.push_back('{data: d, last: l});
    else   srcq0.push_back('{data: d, last: l});
    drive();
  endtask

  // One clock: sample at the falling edge, check against the model, then
  // update sources and the uart model for the next rising edge.
  task automatic tick();
    bit [1:0] v;
    bit       k;
    byte_t    exp;
    @(negedge clock);
    cyc++;
    v = {s1_valid, s0_valid};
    if (uart_clock_enable) begin
      check("issue_uart_idle", busy, 0);
      check("byte_spacing", 32'((cyc - last_strobe) >= int'(GuardTb) + 2), 1);
      if (m_locked)       k = m_owner;
      else if (v == 2'b11) k = !m_owner;
      else                k = v[1];
      check("issue_eligible", v[k], 1);
      if (k) exp = (srcq1.size() > 0) ? srcq1[0] : '0;
      else   exp = (srcq0.size() > 0) ? srcq0[0] : '0;
      check("issue_data", uart_data, exp.data);
      check("issue_ack", {s1_ack, s0_ack}, k ? 2'b10 : 2'b01);
      m_owner  = k;
      m_locked = !exp.last;
      m_data   = exp.data;
      check("issue_owner", owner, m_owner);
      check("issue_locked", locked, m_locked);
      log_q.push_back('{src: k, data: uart_data});
      strobes++;
      last_strobe = cyc;
      busy  = $urandom_range(d_max, d_min);
      stale = GuardTb;
    end else begin
      check("quiet_ack", {s1_ack, s0_ack}, 0);
      check("hold_data", uart_data, m_data);
      check("hold_owner", owner, m_owner);
      if (chk_lock) check("hold_locked", locked, m_locked);
      if (busy > 0) busy--;
      if (stale > 0) stale--;
    end
    if (s0_ack && srcq0.size() > 0) void'(srcq0.pop_front());
    if (s1_ack && srcq1.size() > 0) void'(srcq1.pop_front());
    drive();
    uart_ready = (busy == 0) || (stale > 0);
  endtask

  task automatic wait_strobes(input int n, input int bound, input string name);
    int target = strobes + n;
    int t = 0;
    while (strobes < target && t < bound) begin
      tick();
      t++;
    end
    check(name, strobes, target);
  endtask

  task automatic reset_checks();
    check("rst_data", uart_data, 0);
    check("rst_strobe", uart_clock_enable, 0);
    check("rst_ack", {s1_ack, s0_ack}, 0);
    check("rst_owner", owner, 1);
    check("rst_locked", locked, 0);
    check("rst_flag", timeout_flag, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    srcq0.delete();
    srcq1.delete();
    drive();
    m_owner = 1'b1; m_locked = 1'b0; m_data = 8'h00;
    busy = 0; stale = 0; uart_ready = 1'b1; last_strobe = -100;
    #1;
    reset_checks();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t, k, len, nframes;
    reset = 1'b1;
    uart_ready = 1'b1;
    drive();
    rows[0] = '{1, 1, 8'h21, 8'h31, 1, 1, 2, 0, 8'h21, 1, 0};
    rows[1] = '{1, 0, 8'h22, 8'h00, 0, 0, 1, 0, 8'h22, 0, 1};
    rows[2] = '{1, 1, 8'h23, 8'h32, 1, 1, 2, 0, 8'h23, 1, 0};
    rows[3] = '{1, 1, 8'h24, 8'h33, 1, 0, 2, 0, 8'h24, 1, 1};
    rows[4] = '{1, 1, 8'h25, 8'h34, 1, 1, 2, 1, 8'h34, 0, 0};
    rows[5] = '{0, 1, 8'h00, 8'h35, 0, 1, 1, 1, 8'h35, 1, 0};
    rows[6] = '{1, 1, 8'h26, 8'h36, 0, 1, 1, 0, 8'h26, 0, 1};
    rows[7] = '{1, 0, 8'h27, 8'h00, 1, 0, 2, 0, 8'h27, 1, 0};
    #2;
    apply_reset();

    // Table-driven arbitration vectors, chained from the reset state.
    d_min = 3; d_max = 3;
    for (int i = 0; i < 8; i++) begin
      base = log_q.size();
      if (rows[i].v0) push(0, rows[i].d0, rows[i].l0);
      if (rows[i].v1) push(1, rows[i].d1, rows[i].l1);
      wait_strobes(rows[i].n_issue, 60, "row_issue_count");
      if (log_q.size() > base) begin
        check("row_first_src", log_q[base].src, rows[i].exp_src);
        check("row_first_data", log_q[base].data, rows[i].exp_data);
      end
      check("row_owner", owner, rows[i].exp_owner);
      check("row_locked", locked, rows[i].exp_locked);
    end

    // Six-byte frame from source 0, ready back 4 cycles after each strobe.
    apply_reset();
    d_min = 4; d_max = 4;
    base = log_q.size();
    for (int i = 0; i < 6; i++) push(0, 8'h11 + 8'(i), i == 5);
    wait_strobes(6, 200, "frame6_count");
    for (int i = 0; i < 6; i++) begin
      if (log_q.size() > base + i) begin
        check("frame6_data", log_q[base+i].data, 8'h11 + 8'(i));
        check("frame6_src", log_q[base+i].src, 0);
      end
    end
    check("frame6_unlocked", locked, 0);

    // Both sources loaded with single-byte frames: grants alternate.
    apply_reset();
    d_min = 3; d_max = 3;
    base = log_q.size();
    for (int i = 0; i < 4; i++) begin
      push(0, 8'h50 + 8'(i), 1);
      push(1, 8'h60 + 8'(i), 1);
    end
    wait_strobes(8, 200, "alt_count");
    for (int i = 0; i < 8; i++)
      if (log_q.size() > base + i) check("alt_src", log_q[base+i].src, 32'(i % 2));

    // Source 1 held off while source 0 is mid-frame.
    apply_reset();
    base = log_q.size();
    push(0, 8'h11, 0);
    push(1, 8'hA5, 1);
    wait_strobes(1, 20, "lock_first");
    t = strobes;
    repeat (12) tick();
    check("lock_no_issue", strobes, t);
    check("lock_s1_pending", srcq1.size(), 1);
    push(0, 8'h12, 1);
    wait_strobes(2, 40, "lock_release");
    if (log_q.size() >= base + 3) begin
      check("lock_last_data", log_q[base+1].data, 8'h12);
      check("lock_next_src", log_q[base+2].src, 1);
      check("lock_next_data", log_q[base+2].data, 8'hA5);
    end

    // uart_ready stuck low for 100 cycles after a strobe.
    apply_reset();
    d_min = 100; d_max = 100;
    push(0, 8'h40, 1);
    push(0, 8'h41, 1);
    wait_strobes(1, 20, "stuck_first");
    t = cyc;
    wait_strobes(1, 200, "stuck_second");
    check("stuck_gap", 32'((cyc - t) >= 100), 1);
    t = strobes;
    d_min = 3; d_max = 3;
    repeat (10) tick();
    check("stuck_single", strobes, t);

    // Reset asserted while the arbiter is in its guard interval.
    apply_reset();
    push(0, 8'h77, 0);
    wait_strobes(1, 20, "rg_issue");
    check("rg_locked_before", locked, 1);
    apply_reset();
    base = log_q.size();
    push(1, 8'h3C, 1);
    wait_strobes(1, 20, "rg_s1_issue");
    if (log_q.size() > base) begin
      check("rg_s1_src", log_q[base].src, 1);
      check("rg_s1_data", log_q[base].data, 8'h3C);
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Stalled locked frame is forcibly released after 16 idle cycles.
    apply_reset();
    d_min = 2; d_max = 2;
    push(0, 8'h11, 0);
    wait_strobes(1, 20, "to_first");
    push(1, 8'h5A, 1);
    repeat (10) tick();
    check("to_still_locked", locked, 1);
    check("to_flag_clear", timeout_flag, 0);
    chk_lock = 1'b0;
    t = 0;
    while (locked && t < 40) begin
      tick();
      t++;
    end
    check("to_release", locked, 0);
    check("to_flag_set", timeout_flag, 1);
    m_locked = 1'b0;
    chk_lock = 1'b1;
    base = log_q.size();
    wait_strobes(1, 20, "to_s1_issue");
    if (log_q.size() > base) check("to_s1_data", log_q[base].data, 8'h5A);
    check("to_flag_sticky", timeout_flag, 1);
`endif

    // Random traffic: whole frames arrive on random sources.
    apply_reset();
    d_min = 2; d_max = 6;
    nframes = 0;
    repeat (1500) begin
      if ($urandom_range(5, 0) == 0 && nframes < 80) begin
        k   = $urandom_range(1, 0);
        len = $urandom_range(4, 1);
        for (int j = 0; j < len; j++) push(k[0], 8'($urandom), j == len - 1);
        nframes++;
      end
      tick();
    end
    t = 0;
    while ((srcq0.size() + srcq1.size()) > 0 && t < 3000) begin
      tick();
      t++;
    end
    check("random_drain", srcq0.size() + srcq1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_arbiter.md
Name: uart_arbiter

Overview:
- Shares the single uart_tx byte channel between two framed byte sources: source 0 is the LPC record stream from mem2serial, source 1 is a status/heartbeat reporter.
- Grants whole frames atomically and alternates round-robin at frame boundaries.
- Drives uart_tx's read_data/read_clock_enable pair and obeys its ready.

Parameters:
GUARD, 2, cycles after each byte issue during which uart_ready is ignored (must be >=1)
TIMEOUT, 4096, max idle cycles inside a locked frame before forced release (optional feature only)

Ports:
clock  in  1  system clock (ext_clock domain)
reset  in  1  asynchronous, active-low reset
s0_valid  in  1  source 0 byte available; held until s0_ack
s0_data  in  8  source 0 byte
s0_last  in  1  byte is final byte of its frame
s0_ack  out  1  one-cycle pulse: source 0 byte consumed
s1_valid  in  1  source 1 byte available
s1_data  in  8  source 1 byte
s1_last  in  1  final byte of source 1 frame
s1_ack  out  1  one-cycle pulse: source 1 byte consumed
uart_ready  in  1  uart_tx idle
uart_data  out  8  byte to uart_tx
uart_clock_enable  out  1  one-cycle issue strobe to uart_tx
owner  out  1  source index of current/last granted frame
locked  out  1  frame in progress
timeout_flag  out  1  sticky frame-timeout error (optional feature only; else tied 0)

Behaviour:
- Reset (reset=0, async): state IDLE; uart_data=0, uart_clock_enable=0, s0_ack=s1_ack=0, locked=0, owner=1 (so s0 wins the first tie), guard count 0, timeout_flag=0. Reset mid-byte or mid-frame abandons it; no partial recovery.
- All outputs registered.
- States: IDLE, GUARD, WAIT.
- IDLE:
  - Waits for uart_ready=1 and an eligible valid.
  - If locked, eligible = owner's valid only. Otherwise: if both valid, pick the source != owner; else pick the single valid source.
  - On the edge: uart_data<=selected data, uart_clock_enable<=1, sK_ack<=1 (same cycle, one cycle wide), owner<=K, locked<=~sK_last, guard count<=GUARD, go to GUARD.
- GUARD:
  - Strobe and ack drop after one cycle.
  - Count down; at 0 go to WAIT. uart_ready is ignored here, which covers uart_tx's ready-drop latency.
- WAIT: when uart_ready=1, go to IDLE.
- Minimum byte period is GUARD+2 cycles. A source sees its ack and updates valid/data by the next edge, so no byte is sampled twice.
- A valid from the non-owner while locked is held off indefinitely; no ack.
- The last byte clears the lock in the same edge it is issued. The next frame is arbitrated in the following IDLE using the updated owner.
- Simultaneous valid on both sources with no lock: the source != owner wins; owner toggles per frame under continuous load.
- uart_data holds its last value between issues.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With it defined:
  - A counter runs in IDLE while locked and the owner's valid=0, and is cleared on each issue.
  - On reaching TIMEOUT: locked<=0, timeout_flag<=1 (sticky until reset), and arbitration reopens.
- Without it: no counter, timeout_flag tied 0, and the lock is held until a last byte.

Decomposition:
- Shared package: state enum (IDLE/GUARD/WAIT), source-index type (1 bit), default GUARD/TIMEOUT constants.
- One sub-module: arb_rr2, a combinational 2-way round-robin picker. Inputs: valid[1:0], owner, locked. Outputs: grant and index.

Test Plan:
- Reset, then s0 sends a 6-byte frame 0x11..0x16 with last on 0x16 and uart_ready returning 4 cycles after each strobe -> six strobes with uart_data 0x11..0x16 in order, six s0_ack pulses, locked=1 after first byte and 0 after sixth.
- Both valid from reset with 1-byte frames (last=1) continuously -> grants alternate s0,s1,s0,s1; owner toggles each frame.
- s0 mid-frame (locked after 0x11), s1_valid held high with 0xA5 -> no s1_ack until s0 issues its last byte; then 0xA5 issued next.
- uart_ready stuck low 100 cycles after a strobe -> no further strobe or ack until ready rises, then exactly one issue.
- Assert reset low during GUARD -> all outputs 0, owner=1, locked=0 immediately; after release, a new s1 byte 0x3C issues normally.
- With UART_ARB_TIMEOUT_EN and TIMEOUT=16: s0 sends a non-last byte then drops valid -> after 16 idle cycles locked=0, timeout_flag=1; pending s1 byte then granted.
